// File: rtl/add32_arb_pkg.sv
// add32_rr_arbiter shared types and constants.
// Operand width defaults and the index-width helper.
package add32_arb_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int SLICE_W    = WORD_W_DEF;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/add32_rr_arbiter_rr_pick.sv
// rr_pick: circular priority picker.
// Searches upward from ptr, wrapping N-1 -> 0.
module rr_pick
  import add32_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/add32_rr_arbiter.sv
// Round-robin shared 32-bit adder with registered result stage.
// Define ADD32_ARB_FLAGS_EN to add res_carry/res_ovf outputs.
module add32_rr_arbiter
  import add32_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_a,
  input  logic [NUM_REQ*WORD_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WORD_W-1:0]         res_sum,
  output logic [ID_W-1:0]           res_id
`ifdef ADD32_ARB_FLAGS_EN
  ,
  output logic                      res_carry,
  output logic                      res_ovf
`endif
);

  logic                 out_free;
  logic                 any;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gidx;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      nxt_ptr;
  logic [WORD_W-1:0]    a_g;
  logic [WORD_W-1:0]    b_g;

  assign out_free  = !res_valid || res_ready;
  assign elig      = req_valid & {NUM_REQ{out_free}};
  assign req_ready = gnt;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign a_g = req_a[int'(gidx)*WORD_W +: WORD_W];
  assign b_g = req_b[int'(gidx)*WORD_W +: WORD_W];

  assign nxt_ptr = (gidx == ID_W'(NUM_REQ-1)) ?
                   '0 : gidx + 1'b1;

`ifdef ADD32_ARB_FLAGS_EN
  logic [WORD_W:0] sum;
  logic            ovf;

  assign sum = {1'b0, a_g} + {1'b0, b_g};
  assign ovf = (a_g[WORD_W-1] == b_g[WORD_W-1]) &&
               (sum[WORD_W-1] != a_g[WORD_W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
    end else if (any) begin
      res_carry <= sum[WORD_W];
      res_ovf   <= ovf;
    end
  end
`else
  logic [WORD_W-1:0] sum;

  assign sum = a_g + b_g;
`endif

  // Stall falls out naturally: elig is zero, so nothing loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (any) begin
      res_valid <= 1'b1;
      res_sum   <= sum[WORD_W-1:0];
      res_id    <= gidx;
      rr_ptr    <= nxt_ptr;
    end else if (out_free) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add32_rr_arbiter.sv
// Scoreboard bench for add32_rr_arbiter.
// Honours ADD32_ARB_FLAGS_EN for the flag outputs.
module tb_add32_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         c;
    logic         v;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic [1:0]     res_id;
`ifdef ADD32_ARB_FLAGS_EN
  logic           res_carry;
  logic           res_ovf;
`endif

  int           nvec = 0;
  int           nerr = 0;
  exp_t         q[$];
  int           m_ptr = 0;
  logic [N-1:0] last_gnt;

  always #5 clk = ~clk;

  add32_rr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
`ifdef ADD32_ARB_FLAGS_EN
    ,
    .res_carry (res_carry),
    .res_ovf   (res_ovf)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_op(input int i,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One cycle: check outputs, model grant, advance.
  task automatic step();
    exp_t         e;
    logic [N-1:0] eg;
    logic         free;
    logic [W:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           g;
    int           j;
    @(negedge clk);
    if (q.size() > 0) begin
      chk("res_valid", 64'(res_valid), 64'd1);
      chk("res_sum", 64'(res_sum), 64'(q[0].sum));
      chk("res_id", 64'(res_id), 64'(q[0].id));
`ifdef ADD32_ARB_FLAGS_EN
      chk("res_carry", 64'(res_carry), 64'(q[0].c));
      chk("res_ovf", 64'(res_ovf), 64'(q[0].v));
`endif
    end else begin
      chk("res_valid", 64'(res_valid), 64'd0);
    end
    free = (q.size() == 0) || res_ready;
    eg = '0;
    g  = -1;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eg));
    if (q.size() > 0 && res_ready) void'(q.pop_front());
    if (g >= 0) begin
      a = req_a[g*W +: W];
      b = req_b[g*W +: W];
      s = {1'b0, a} + {1'b0, b};
      e.id  = g[1:0];
      e.sum = s[W-1:0];
      e.c   = s[W];
      e.v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      q.push_back(e);
      m_ptr = (g + 1) % N;
    end
    last_gnt = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_ptr = 0;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_sum", 64'(res_sum), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    last_gnt  = '0;
    do_reset();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);

    // single request 5+7
    set_op(0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    chk("single_sum", 64'(res_sum), 64'd12);
    step();
    step();

    // all four continuously, grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++)
      set_op(i, 32'(100 * (i + 1)), 32'(i + 3));
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) step();

    // backpressure for 3 cycles
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    step();

    // wrap-around and flags
    do_reset();
    set_op(0, 32'hFFFF_FFFF, 32'd1);
    req_valid = 4'b0001;
    step();
    chk("wrap_sum", 64'(res_sum), 64'd0);
`ifdef ADD32_ARB_FLAGS_EN
    chk("wrap_c", 64'(res_carry), 64'd1);
    chk("wrap_v", 64'(res_ovf), 64'd0);
`endif
    set_op(1, 32'h7FFF_FFFF, 32'd1);
    req_valid = 4'b0010;
    step();
    chk("ovf_sum", 64'(res_sum), 64'h8000_0000);
`ifdef ADD32_ARB_FLAGS_EN
    chk("ovf_c", 64'(res_carry), 64'd0);
    chk("ovf_v", 64'(res_ovf), 64'd1);
`endif
    req_valid = '0;
    step();

    // pointer holds across idle cycles
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    req_valid = 4'b1111;
    #1;
    chk("ptr_hold", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    step();

    // reset with a pending result and a live request
    do_reset();
    set_op(0, 32'd1, 32'd2);
    set_op(1, 32'd9, 32'd9);
    req_valid = 4'b0001;
    res_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    do_reset();
    res_ready = 1'b1;
    req_valid = '0;
    step();
    req_valid = 4'b1111;
    #1;
    chk("rst_ptr", 64'(req_ready), 64'b0001);
    step();

    // random traffic, operands held until accepted
    req_valid = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_gnt[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i, $urandom, $urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
